// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// MEM has fixed priority; a streak guard lets a waiting fetch in; flushed fetch responses are dropped.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [1:0]          mem_size,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_wen,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [1:0]          bus_size,
  input  logic                bus_resp_valid,
  input  logic [DATA_W-1:0]   bus_resp_data,
  input  logic                bus_resp_err,
  output logic                if_stall_req,
  output logic                mem_stall_req
);
  localparam int STRB_W = DATA_W / 8;
  localparam int SW     = (MEM_STREAK_MAX > 0) ? $clog2(MEM_STREAK_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_LIM = SW'(MEM_STREAK_MAX);
  localparam bit GUARD_EN = (MEM_STREAK_MAX != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              drop_q, drop_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        size_q, size_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;
  logic              if_err_q, if_err_d;
  logic              mem_err_q, mem_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic if_elig, mem_elig, guard_hit, grant_if, grant_mem, kill;

  // A requester whose ready pulses this cycle is still showing its old valid.
  assign if_elig   = if_valid & ~if_ready_q & ~if_flush;
  assign mem_elig  = mem_valid & ~mem_ready_q;
  assign guard_hit = GUARD_EN & (streak_q == STREAK_LIM);
  assign grant_if  = (state_q == S_IDLE) & if_elig & (~mem_elig | guard_hit);
  assign grant_mem = (state_q == S_IDLE) & mem_elig & ~grant_if;
  assign kill      = if_flush & (owner_q == OWN_IF) & (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q | kill;
    streak_d    = streak_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_err_d    = 1'b0;
    mem_err_d   = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (grant_if) begin
          state_d  = S_REQ;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          size_d   = 2'd3;
          streak_d = '0;
        end else if (grant_mem) begin
          state_d  = S_REQ;
          owner_d  = OWN_MEM;
          addr_d   = mem_addr;
          wen_d    = mem_wen;
          wdata_d  = mem_wdata;
          wstrb_d  = mem_wstrb;
          size_d   = mem_size;
          if (!if_valid)
            streak_d = '0;
          else if (streak_q != STREAK_LIM)
            streak_d = streak_q + 1'b1;
        end
      end
      S_REQ: begin
        if (bus_req_ready) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus_resp_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          rdata_d = bus_resp_data;
          if (owner_q == OWN_MEM) begin
            mem_ready_d = 1'b1;
            mem_err_d   = bus_resp_err;
          end else if (!(drop_q | if_flush)) begin
            if_ready_d = 1'b1;
            if_err_d   = bus_resp_err;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      streak_q    <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      size_q      <= 2'd0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_err_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_err_q    <= if_err_d;
      mem_err_q   <= mem_err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus_req_valid = (state_q == S_REQ);
  assign bus_addr      = addr_q;
  assign bus_wen       = wen_q;
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_size      = size_q;
  assign if_ready      = if_ready_q;
  assign if_err        = if_err_q;
  assign if_rdata      = rdata_q;
  assign mem_ready     = mem_ready_q;
  assign mem_err       = mem_err_q;
  assign mem_rdata     = rdata_q;
  assign if_stall_req  = if_valid & ~if_ready_q;
  assign mem_stall_req = mem_valid & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int SMAX   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid, if_flush, if_ready, if_err;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_valid, mem_wen, mem_ready, mem_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [1:0]        mem_size;
  logic              bus_req_valid, bus_req_ready, bus_wen;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [STRB_W-1:0] bus_wstrb;
  logic [1:0]        bus_size;
  logic              bus_resp_valid, bus_resp_err;
  logic [DATA_W-1:0] bus_resp_data;
  logic              if_stall_req, mem_stall_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_size(mem_size),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_size(bus_size),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_err(bus_resp_err),
    .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_valid = 1'b0; mem_addr = '0; mem_wen = 1'b0;
    mem_wdata = '0; mem_wstrb = '0; mem_size = 2'd0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_resp_data = '0; bus_resp_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    #1;
    n_cmp++;
    if ({bus_req_valid, if_ready, mem_ready, if_err, mem_err, bus_wen} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus_req_valid, if_ready, mem_ready, if_err, mem_err, bus_wen});
    end
    n_cmp++;
    if (bus_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0h want 0", bus_addr); end
    n_cmp++;
    if ({bus_wdata, bus_wstrb, bus_size} !== '0) begin
      n_bad++; $display("FAIL reset_payload: got %0h want 0", {bus_wdata, bus_wstrb, bus_size});
    end
    n_cmp++;
    if ({if_rdata, mem_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_rdata: got %0h want 0", {if_rdata, mem_rdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    do_reset();
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 64'h13;
    if_valid = 1'b1; if_addr = 64'h8000_0000;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc();
      #1;
      n_cmp++;
      if (if_stall_req !== (c <= 2)) begin
        n_bad++; $display("FAIL ifrd_stall c%0d: got %b want %b", c, if_stall_req, (c <= 2));
      end
      n_cmp++;
      if (bus_req_valid !== (c == 1)) begin
        n_bad++; $display("FAIL ifrd_brv c%0d: got %b want %b", c, bus_req_valid, (c == 1));
      end
      n_cmp++;
      if (if_ready !== (c == 3)) begin
        n_bad++; $display("FAIL ifrd_ready c%0d: got %b want %b", c, if_ready, (c == 3));
      end
      if (c == 1) begin
        n_cmp++;
        if ({bus_addr, bus_size, bus_wen} !== {64'h8000_0000, 2'd3, 1'b0}) begin
          n_bad++; $display("FAIL ifrd_payload: got %0h/%0d/%b want 80000000/3/0", bus_addr, bus_size, bus_wen);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({if_rdata, if_err, mem_ready} !== {64'h13, 1'b0, 1'b0}) begin
          n_bad++; $display("FAIL ifrd_data: got %0h err %b mrdy %b want 13 0 0", if_rdata, if_err, mem_ready);
        end
        if_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mem_priority();
    do_reset();
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1; bus_resp_data = 64'hA5A5;
    if_valid = 1'b1; if_addr = 64'h8000_1000;
    mem_valid = 1'b1; mem_addr = 64'h100; mem_size = 2'd2; mem_wen = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) cyc();
      #1;
      if (c == 1) begin
        n_cmp++;
        if ({bus_req_valid, bus_addr, bus_size} !== {1'b1, 64'h100, 2'd2}) begin
          n_bad++; $display("FAIL prio_first: got v%b %0h sz%0d want v1 100 sz2", bus_req_valid, bus_addr, bus_size);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if ({mem_ready, if_ready, mem_rdata} !== {1'b1, 1'b0, 64'hA5A5}) begin
          n_bad++; $display("FAIL prio_mem_done: got m%b i%b %0h want m1 i0 a5a5", mem_ready, if_ready, mem_rdata);
        end
        mem_valid = 1'b0;
        bus_resp_data = 64'h1234;
      end
      if (c == 4) begin
        n_cmp++;
        if ({bus_req_valid, bus_addr, bus_size} !== {1'b1, 64'h8000_1000, 2'd3}) begin
          n_bad++; $display("FAIL prio_second: got v%b %0h sz%0d want v1 80001000 sz3", bus_req_valid, bus_addr, bus_size);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({if_ready, mem_ready, if_rdata} !== {1'b1, 1'b0, 64'h1234}) begin
          n_bad++; $display("FAIL prio_if_done: got i%b m%b %0h want i1 m0 1234", if_ready, mem_ready, if_rdata);
        end
        if_valid = 1'b0;
      end
    end
  endtask

  task automatic test_streak();
    bit got_if [6];
    bit want_if [6];
    int ng;
    bit prev;
    want_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ng = 0;
    prev = 1'b0;
    do_reset();
    bus_req_ready = 1'b1; bus_resp_valid = 1'b1;
    if_valid = 1'b1; if_addr = 64'h8000_4000;
    mem_valid = 1'b1; mem_addr = 64'h1000; mem_size = 2'd2;
    for (int c = 0; c < 80 && ng < 6; c++) begin
      if (c > 0) cyc();
      #1;
      if (bus_req_valid && !prev) begin
        got_if[ng] = (bus_size == 2'd3);
        ng++;
      end
      prev = bus_req_valid;
      if (if_ready) if_valid = 1'b0;
      // Hold IF off only in MEM's completion cycle so each later contest is a real MEM-vs-IF race.
      if (mem_ready) begin
        mem_addr = mem_addr + 64'd8;
        if_flush = 1'b1;
      end else begin
        if_flush = 1'b0;
      end
    end
    n_cmp++;
    if (ng != 6) begin n_bad++; $display("FAIL streak_count: got %0d grants want 6", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++;
      if (got_if[i] !== want_if[i]) begin
        n_bad++; $display("FAIL streak_order[%0d]: got is_if=%b want %b", i, got_if[i], want_if[i]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
    if_valid = 1'b1; if_addr = 64'h8000_0100;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) cyc();
      #1;
      n_cmp++;
      if (if_ready !== (c == 8)) begin
        n_bad++; $display("FAIL flush_ready c%0d: got %b want %b", c, if_ready, (c == 8));
      end
      case (c)
        2: begin if_flush = 1'b1; if_addr = 64'h8000_2000; end
        3: if_flush = 1'b0;
        4: begin bus_resp_valid = 1'b1; bus_resp_data = 64'hDEAD; end
        5: bus_resp_valid = 1'b0;
        6: begin
          n_cmp++;
          if ({bus_req_valid, bus_addr} !== {1'b1, 64'h8000_2000}) begin
            n_bad++; $display("FAIL flush_refetch: got v%b %0h want v1 80002000", bus_req_valid, bus_addr);
          end
        end
        7: begin bus_resp_valid = 1'b1; bus_resp_data = 64'h77; end
        8: begin
          n_cmp++;
          if (if_rdata !== 64'h77) begin n_bad++; $display("FAIL flush_data: got %0h want 77", if_rdata); end
          if_valid = 1'b0; bus_resp_valid = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_store_backpressure();
    int pulses;
    pulses = 0;
    do_reset();
    mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 64'h200; mem_wstrb = 8'h0F;
    mem_wdata = 64'h1122_3344_5566_7788; mem_size = 2'd2;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) cyc();
      #1;
      if (mem_ready) pulses++;
      if (c >= 1 && c <= 5) begin
        n_cmp++;
        if ({bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata, bus_size} !==
            {1'b1, 1'b1, 64'h200, 8'h0F, 64'h1122_3344_5566_7788, 2'd2}) begin
          n_bad++; $display("FAIL store_hold c%0d: got v%b w%b %0h %0h %0h", c, bus_req_valid, bus_wen, bus_addr, bus_wstrb, bus_wdata);
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (mem_stall_req !== 1'b1) begin n_bad++; $display("FAIL store_stall: got %b want 1", mem_stall_req); end
      end
      if (c == 5) bus_req_ready = 1'b1;
      if (c == 6) begin
        n_cmp++;
        if (bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL store_resp_phase: got %b want 0", bus_req_valid); end
        bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hFFFF;
      end
      if (c == 7) begin
        n_cmp++;
        if ({mem_ready, mem_err} !== 2'b10) begin
          n_bad++; $display("FAIL store_done: got rdy%b err%b want rdy1 err0", mem_ready, mem_err);
        end
        mem_valid = 1'b0; bus_resp_valid = 1'b0;
      end
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL store_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_req_ready = 1'b1; bus_resp_valid = 1'b0;
    mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = 64'h300; mem_size = 2'd2;
    cyc();
    cyc();
    rst = 1'b1; mem_valid = 1'b0;
    cyc();
    rst = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hBAD;
    #1;
    n_cmp++;
    if ({bus_req_valid, bus_addr, mem_ready, mem_rdata} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got v%b %0h r%b %0h want all 0", bus_req_valid, bus_addr, mem_ready, mem_rdata);
    end
    cyc();
    #1;
    n_cmp++;
    if ({mem_ready, if_ready, bus_req_valid} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_stale: got %b want 000", {mem_ready, if_ready, bus_req_valid});
    end
    bus_resp_err = 1'b1; bus_resp_data = 64'h4444;
    mem_valid = 1'b1; mem_addr = 64'h400; mem_size = 2'd3;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) cyc();
      #1;
      n_cmp++;
      if ({mem_ready, mem_err} !== {(c == 3), (c == 3)}) begin
        n_bad++; $display("FAIL rstmid_err c%0d: got rdy%b err%b want %b%b", c, mem_ready, mem_err, (c == 3), (c == 3));
      end
    end
    mem_valid = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
  endtask

  // Reference: at most one transaction record; the grant rule, streak count and drop flag
  // are evaluated from each cycle's inputs exactly as the arbitration rules read.
  task automatic test_random();
    bit txn, acc, drop, who_mem;
    int streak;
    logic [ADDR_W-1:0] e_addr;
    logic              e_wen;
    logic [DATA_W-1:0] e_wdata, e_rdata;
    logic [STRB_W-1:0] e_wstrb;
    logic [1:0]        e_size;
    bit e_ifr, e_memr, e_ife, e_meme;
    bit n_ifr, n_memr, n_ife, n_meme;
    bit if_pend, mem_pend, ie, me;
    txn = 0; acc = 0; drop = 0; who_mem = 0; streak = 0;
    e_addr = '0; e_wen = 0; e_wdata = '0; e_rdata = '0; e_wstrb = '0; e_size = 2'd0;
    e_ifr = 0; e_memr = 0; e_ife = 0; e_meme = 0;
    if_pend = 0; mem_pend = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      #1;
      n_cmp++;
      if (bus_req_valid !== (txn && !acc)) begin
        n_bad++; $display("FAIL rnd_brv c%0d: got %b want %b", c, bus_req_valid, (txn && !acc));
      end
      if (txn && !acc) begin
        n_cmp++;
        if ({bus_addr, bus_wen, bus_size} !== {e_addr, e_wen, e_size}) begin
          n_bad++; $display("FAIL rnd_payload c%0d: got %0h w%b s%0d want %0h w%b s%0d", c, bus_addr, bus_wen, bus_size, e_addr, e_wen, e_size);
        end
        if (who_mem) begin
          n_cmp++;
          if ({bus_wdata, bus_wstrb} !== {e_wdata, e_wstrb}) begin
            n_bad++; $display("FAIL rnd_wdata c%0d: got %0h/%0h want %0h/%0h", c, bus_wdata, bus_wstrb, e_wdata, e_wstrb);
          end
        end
      end
      n_cmp++;
      if ({if_ready, mem_ready, if_err, mem_err} !== {e_ifr, e_memr, e_ife, e_meme}) begin
        n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {if_ready, mem_ready, if_err, mem_err}, {e_ifr, e_memr, e_ife, e_meme});
      end
      if (e_ifr) begin
        n_cmp++;
        if (if_rdata !== e_rdata) begin n_bad++; $display("FAIL rnd_ifdata c%0d: got %0h want %0h", c, if_rdata, e_rdata); end
      end
      if (e_memr) begin
        n_cmp++;
        if (mem_rdata !== e_rdata) begin n_bad++; $display("FAIL rnd_memdata c%0d: got %0h want %0h", c, mem_rdata, e_rdata); end
      end

      if (e_ifr) if_pend = 0;
      if (e_memr) mem_pend = 0;
      if_flush = ($urandom_range(15) == 0);
      if (if_flush || (!if_pend && $urandom_range(2) == 0)) begin
        if_pend = 1;
        if_addr = {$urandom(), $urandom()};
      end
      if (!mem_pend && $urandom_range(2) == 0) begin
        mem_pend  = 1;
        mem_addr  = {$urandom(), $urandom()};
        mem_wen   = 1'($urandom_range(1));
        mem_wdata = {$urandom(), $urandom()};
        mem_wstrb = 8'($urandom());
        mem_size  = 2'($urandom_range(3));
      end
      if_valid = if_pend;
      mem_valid = mem_pend;
      bus_req_ready  = 1'($urandom_range(1));
      bus_resp_valid = ($urandom_range(2) == 0);
      bus_resp_data  = {$urandom(), $urandom()};
      bus_resp_err   = ($urandom_range(7) == 0);
      #1;
      n_cmp++;
      if ({if_stall_req, mem_stall_req} !== {if_valid && !e_ifr, mem_valid && !e_memr}) begin
        n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {if_stall_req, mem_stall_req}, {if_valid && !e_ifr, mem_valid && !e_memr});
      end

      n_ifr = 0; n_memr = 0; n_ife = 0; n_meme = 0;
      ie = if_valid && !e_ifr && !if_flush;
      me = mem_valid && !e_memr;
      if (!txn) begin
        if (ie && (!me || streak == SMAX)) begin
          txn = 1; acc = 0; drop = 0; who_mem = 0;
          e_addr = if_addr; e_wen = 0; e_size = 2'd3;
          streak = 0;
        end else if (me) begin
          txn = 1; acc = 0; drop = 0; who_mem = 1;
          e_addr = mem_addr; e_wen = mem_wen; e_size = mem_size;
          e_wdata = mem_wdata; e_wstrb = mem_wstrb;
          streak = if_valid ? ((streak < SMAX) ? streak + 1 : streak) : 0;
        end
      end else begin
        if (!who_mem && if_flush) drop = 1;
        if (!acc) begin
          if (bus_req_ready) acc = 1;
        end else if (bus_resp_valid) begin
          txn = 0;
          e_rdata = bus_resp_data;
          if (who_mem) begin
            n_memr = 1; n_meme = bus_resp_err;
          end else if (!drop) begin
            n_ifr = 1; n_ife = bus_resp_err;
          end
        end
      end
      e_ifr = n_ifr; e_memr = n_memr; e_ife = n_ife; e_meme = n_meme;
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_mem_priority();
    test_streak();
    test_flush();
    test_store_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
